vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one single-port, synchronous-read video RAM between the display pixel fetch and N drawing clients that write to it.
- Display reads have absolute priority and a fixed latency, so the pixel pipeline driven by the 40 MHz pixel strobe never slips.
- Write clients are served round-robin in cycles the display does not use.
- Sits between the VGA timing/pixel path and the framebuffer RAM.

Parameters:
ADDR_W, 16, VRAM address width
DATA_W, 8, VRAM data width (pixel word)
N_WR, 2, number of write clients (1..8)

Ports:
i_clk  in  1  system clock (100 MHz)
i_rst_n  in  1  asynchronous, active-low reset
i_disp_req  in  1  display read request, single-cycle pulse (typically once per pixel strobe)
i_disp_addr  in  ADDR_W  display read address, sampled with i_disp_req
o_disp_data  out  DATA_W  read data, registered
o_disp_valid  out  1  o_disp_data valid, single-cycle pulse
i_wr_req  in  N_WR  per-client write request, level
i_wr_addr  in  N_WR*ADDR_W  packed write addresses; client k at [k*ADDR_W +: ADDR_W]
i_wr_data  in  N_WR*DATA_W  packed write data
o_wr_ack  out  N_WR  per-client write accepted, one-hot pulse
o_ram_we  out  1  RAM write enable, registered
o_ram_addr  out  ADDR_W  RAM address, registered
o_ram_wdata  out  DATA_W  RAM write data, registered
i_ram_rdata  in  DATA_W  RAM read data, valid one cycle after the address

Behaviour:
- Reset: async on i_rst_n low.
  - Clears o_disp_valid, o_disp_data=0, o_wr_ack=0, o_ram_we=0, o_ram_addr=0, o_ram_wdata=0.
  - Round-robin pointer resets to 0; read-valid pipeline flushed.
  - Release is taken on the clock edge; the first arbitration happens in the first cycle with i_rst_n high.
- Arbitration (cycle T, on the inputs sampled that cycle):
  - If i_disp_req=1, a read is issued: T+1 o_ram_we=0, o_ram_addr=i_disp_addr. No write is granted in T.
  - Otherwise, if any i_wr_req bit is set, grant the first requesting client at or after the pointer (wrapping modulo N_WR). T+1 drives o_ram_we=1, o_ram_addr/o_ram_wdata from that client and o_wr_ack[k]=1. The pointer becomes (k+1) mod N_WR.
  - Otherwise T+1 drives o_ram_we=0 and holds o_ram_addr.
- Display read latency is fixed at 3 cycles: request in T, RAM address in T+1, RAM data in T+2, then o_disp_data/o_disp_valid registered in T+3.
  - Back-to-back display requests are accepted every cycle and each produces valid exactly 3 cycles later. Writes fully starve for that period.
- Write handshake:
  - Client holds req/addr/data stable until it sees ack.
  - The RAM write occurs in the ack cycle.
  - req still high in the cycle after ack counts as a new request (a back-to-back write). With other clients requesting, the pointer has moved, so the next grant goes elsewhere first.
- Boundary cases:
  - N_WR=1: the pointer is constant at 0.
  - Display request and all write requests in the same cycle: display wins and no ack is issued.
  - Under a ≤1-in-2 display duty, no requesting client waits more than 2*N_WR cycles.
  - Reset mid-operation: in-flight reads are dropped with no valid; unacked writes stay pending; a write already on the RAM port completes electrically, but its ack pulse is cleared.
- o_wr_ack is at most one-hot. o_disp_valid never coincides with a reset-flushed request.

Optional Feature:
- Macro: VRAM_ARB_STALL_CNT_EN.
- Defined:
  - Adds output o_stall_cnt [15:0]: counts cycles where |i_wr_req=1 and no ack was granted that cycle because of a display read.
  - Saturates at 16'hFFFF; resets to 0 on i_rst_n.
  - Adds input i_stall_clr (1 bit), which synchronously clears the counter and takes precedence over increment.
- Undefined: both ports are absent and there is no counter logic.

Decomposition:
- Shared package vram_pkg: default ADDR_W/DATA_W, DISP_RD_LAT=3, and a clog2 helper for the pointer width.
- One sub-module, rr_arbiter (N requests, enable, one-hot grant, pointer update on grant), instantiated with its enable = ~i_disp_req.

Test Plan:
- Reset, then i_disp_req pulse with addr 0x0123 while the RAM model returns 0x5A: o_ram_addr=0x0123 at T+1; o_disp_valid=1 with o_disp_data=0x5A at exactly T+3; no o_wr_ack.
- Both clients hold req (client0 addr 0x0010/data 0x11, client1 addr 0x0020/data 0x22), no display: acks alternate 0,1,0,1 on consecutive cycles and RAM writes match each ack's client.
- Display req every cycle for 10 cycles with client1 requesting: no ack for 10 cycles, 10 valids each 3 cycles after its request. Client1 acked the first free cycle. With the stall-counter macro defined, o_stall_cnt=10.
- Display req every second cycle, both clients requesting: each client acked within 4 cycles; o_ram_we never high in a cycle carrying a display address.
- Assert i_rst_n=0 one cycle after a display request: no o_disp_valid follows; all outputs 0 asynchronously; after release the pointer restarts at client0.
- N_WR=1 build, continuous req: ack every cycle with no display, the write address reaches RAM each cycle.

Source files
------------

// File: rtl/vram_pkg.sv
// ============================================================================
// vram_pkg : shared sizes, read latency and helpers for the VRAM arbiter
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package vram_pkg;

  localparam int VRAM_ADDR_W = 16;
  localparam int VRAM_DATA_W = 8;
  localparam int DISP_RD_LAT = 3;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_e;

  // A single client still needs a 1-bit pointer register.
  function automatic int ptr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin one-hot grant among N requesters, gated by enable
// Revision   : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rr_arbiter
  import vram_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_en,
  output logic [N-1:0] o_grant
);

  localparam int PW = ptr_width(N);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_nxt;
  logic [N-1:0]  w_grant;
  logic          w_found;

  // Scan from the pointer upward with wrap; the first requester wins.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_nxt   = r_ptr;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!w_found && i_en && i_req[j] && (j == ((int'(r_ptr) + i) % N))) begin
          w_found    = 1'b1;
          w_grant[j] = 1'b1;
          w_nxt      = (j == N - 1) ? '0 : PW'(j + 1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_nxt;
    end
  end

  assign o_grant = w_grant;

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// vram_arbiter : display-priority VRAM port sharing with round-robin writers
// Optional     : VRAM_ARB_STALL_CNT_EN adds o_stall_cnt / i_stall_clr
// Revision     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W,
  parameter int N_WR   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_disp_req,
  input  logic [ADDR_W-1:0]      i_disp_addr,
  output logic [DATA_W-1:0]      o_disp_data,
  output logic                   o_disp_valid,
  input  logic [N_WR-1:0]        i_wr_req,
  input  logic [N_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [N_WR*DATA_W-1:0] i_wr_data,
  output logic [N_WR-1:0]        o_wr_ack,
  output logic                   o_ram_we,
  output logic [ADDR_W-1:0]      o_ram_addr,
  output logic [DATA_W-1:0]      o_ram_wdata,
  input  logic [DATA_W-1:0]      i_ram_rdata
`ifdef VRAM_ARB_STALL_CNT_EN
  ,
  output logic [15:0]            o_stall_cnt,
  input  logic                   i_stall_clr
`endif
);

  localparam int PIPE_W = DISP_RD_LAT - 1;

  logic [N_WR-1:0]   w_grant;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  slot_e             w_slot;

  logic [PIPE_W-1:0] r_rd_pipe;
  logic [DATA_W-1:0] r_disp_data;
  logic              r_disp_valid;
  logic [N_WR-1:0]   r_wr_ack;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;

  rr_arbiter #(
    .N (N_WR)
  ) u_rr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (i_wr_req),
    .i_en    (~i_disp_req),
    .o_grant (w_grant)
  );

  always_comb begin
    w_wr_addr = '0;
    w_wr_data = '0;
    for (int k = 0; k < N_WR; k++) begin
      w_wr_addr = w_wr_addr | ({ADDR_W{w_grant[k]}} & i_wr_addr[k*ADDR_W +: ADDR_W]);
      w_wr_data = w_wr_data | ({DATA_W{w_grant[k]}} & i_wr_data[k*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    w_slot = SLOT_IDLE;
    if (i_disp_req) begin
      w_slot = SLOT_READ;
    end else if (|w_grant) begin
      w_slot = SLOT_WRITE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_wr_ack    <= '0;
    end else begin
      r_wr_ack <= w_grant;
      case (w_slot)
        SLOT_READ: begin
          r_ram_we   <= 1'b0;
          r_ram_addr <= i_disp_addr;
        end
        SLOT_WRITE: begin
          r_ram_we    <= 1'b1;
          r_ram_addr  <= w_wr_addr;
          r_ram_wdata <= w_wr_data;
        end
        default: begin
          r_ram_we <= 1'b0;
        end
      endcase
    end
  end

  // Valid tag follows the address through the RAM's one-cycle read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_pipe    <= '0;
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
    end else begin
      r_rd_pipe    <= {r_rd_pipe[PIPE_W-2:0], i_disp_req};
      r_disp_valid <= r_rd_pipe[PIPE_W-1];
      if (r_rd_pipe[PIPE_W-1]) begin
        r_disp_data <= i_ram_rdata;
      end
    end
  end

`ifdef VRAM_ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_stall_clr) begin
      r_stall_cnt <= '0;
    end else if (i_disp_req && (|i_wr_req) && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

  assign o_disp_data  = r_disp_data;
  assign o_disp_valid = r_disp_valid;
  assign o_wr_ack     = r_wr_ack;
  assign o_ram_we     = r_ram_we;
  assign o_ram_addr   = r_ram_addr;
  assign o_ram_wdata  = r_ram_wdata;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// tb_vram_arbiter : scoreboard bench for vram_arbiter (N_WR=2 and N_WR=1)
// Revision        : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vram_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic [NW-1:0] wr_req = '0;
  logic [NW*AW-1:0] wr_addr = '0;
  logic [NW*DW-1:0] wr_data = '0;
  logic [NW-1:0] wr_ack;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  logic          d1_disp_req = 1'b0;
  logic [AW-1:0] d1_disp_addr = '0;
  logic [DW-1:0] d1_disp_data;
  logic          d1_disp_valid;
  logic [0:0]    d1_wr_req = '0;
  logic [AW-1:0] d1_wr_addr = '0;
  logic [DW-1:0] d1_wr_data = '0;
  logic [0:0]    d1_wr_ack;
  logic          d1_ram_we;
  logic [AW-1:0] d1_ram_addr;
  logic [DW-1:0] d1_ram_wdata;
  logic [DW-1:0] d1_ram_rdata = '0;

`ifdef VRAM_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic        stall_clr = 1'b0;
  logic [15:0] d1_stall_cnt;
  logic        d1_stall_clr = 1'b0;
`endif

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_WR(NW)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_disp_req   (disp_req),
    .i_disp_addr  (disp_addr),
    .o_disp_data  (disp_data),
    .o_disp_valid (disp_valid),
    .i_wr_req     (wr_req),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .o_wr_ack     (wr_ack),
    .o_ram_we     (ram_we),
    .o_ram_addr   (ram_addr),
    .o_ram_wdata  (ram_wdata),
    .i_ram_rdata  (ram_rdata)
`ifdef VRAM_ARB_STALL_CNT_EN
    ,
    .o_stall_cnt  (stall_cnt),
    .i_stall_clr  (stall_clr)
`endif
  );

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_WR(1)) u_dut1 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_disp_req   (d1_disp_req),
    .i_disp_addr  (d1_disp_addr),
    .o_disp_data  (d1_disp_data),
    .o_disp_valid (d1_disp_valid),
    .i_wr_req     (d1_wr_req),
    .i_wr_addr    (d1_wr_addr),
    .i_wr_data    (d1_wr_data),
    .o_wr_ack     (d1_wr_ack),
    .o_ram_we     (d1_ram_we),
    .o_ram_addr   (d1_ram_addr),
    .o_ram_wdata  (d1_ram_wdata),
    .i_ram_rdata  (d1_ram_rdata)
`ifdef VRAM_ARB_STALL_CNT_EN
    ,
    .o_stall_cnt  (d1_stall_cnt),
    .i_stall_clr  (d1_stall_clr)
`endif
  );

  // Synchronous-read single-port RAM; preload pattern chosen so 0x0123 reads 0x5A.
  logic [DW-1:0] mem [0:65535];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h78;
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = pat(AW'(i));
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [AW-1:0] addr; } aexp_t;
  typedef struct { int cyc; logic [DW-1:0] data; } dexp_t;
  typedef struct { int cyc; int k; logic [AW-1:0] addr; logic [DW-1:0] data; } wexp_t;

  aexp_t aq[$];
  dexp_t dq[$];
  wexp_t wq[$];

  int checks = 0;
  int errors = 0;

  function automatic int pending();
    return aq.size() + dq.size() + wq.size();
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (aq.size() > 0 && aq[0].cyc == cyc) begin
        checks++;
        if (ram_we !== 1'b0 || ram_addr !== aq[0].addr) begin
          errors++;
          $display("FAIL rd_addr cyc=%0d got we=%b addr=%h want we=0 addr=%h",
                   cyc, ram_we, ram_addr, aq[0].addr);
        end
        aq.delete(0);
      end
      if (disp_valid === 1'b1) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL rd_data cyc=%0d got unexpected valid data=%h want no valid", cyc, disp_data);
        end else begin
          if (dq[0].cyc != cyc || disp_data !== dq[0].data) begin
            errors++;
            $display("FAIL rd_data got cyc=%0d data=%h want cyc=%0d data=%h",
                     cyc, disp_data, dq[0].cyc, dq[0].data);
          end
          dq.delete(0);
        end
      end
      if (wr_ack !== '0) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL wr_ack cyc=%0d got unexpected ack=%b want none", cyc, wr_ack);
        end else begin
          if (wq[0].cyc != cyc || wr_ack !== (NW'(1) << wq[0].k) || ram_we !== 1'b1 ||
              ram_addr !== wq[0].addr || ram_wdata !== wq[0].data) begin
            errors++;
            $display("FAIL wr_ack got cyc=%0d ack=%b we=%b addr=%h wd=%h want cyc=%0d client=%0d we=1 addr=%h wd=%h",
                     cyc, wr_ack, ram_we, ram_addr, ram_wdata,
                     wq[0].cyc, wq[0].k, wq[0].addr, wq[0].data);
          end
          wq.delete(0);
        end
      end else if (ram_we === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL wr_noack cyc=%0d got we=1 addr=%h want we=0 without ack", cyc, ram_addr);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({disp_valid, disp_data, wr_ack, ram_we} !== '0) begin
      errors++;
      $display("FAIL reset_ctl got valid=%b data=%h ack=%b we=%b want all 0",
               disp_valid, disp_data, wr_ack, ram_we);
    end
    checks++;
    if (ram_addr !== '0 || ram_wdata !== '0) begin
      errors++;
      $display("FAIL reset_ram got addr=%h wd=%h want 0", ram_addr, ram_wdata);
    end
    checks++;
    if (d1_wr_ack !== 1'b0 || d1_ram_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_n1 got ack=%b we=%b want 0", d1_wr_ack, d1_ram_we);
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_single_read();
    disp_req  = 1'b1;
    disp_addr = 16'h0123;
    aq.push_back('{cyc + 1, 16'h0123});
    dq.push_back('{cyc + 3, 8'h5A});
    step(1);
    disp_req = 1'b0;
    step(5);
    checks++;
    if (disp_data !== 8'h5A) begin
      errors++;
      $display("FAIL single_read got data=%h want 5a", disp_data);
    end
    checks++;
    if (pending() != 0) begin
      errors++;
      $display("FAIL single_read_pending got %0d outstanding want 0", pending());
    end
  endtask

  task automatic test_round_robin();
    wr_addr = {16'h0020, 16'h0010};
    wr_data = {8'h22, 8'h11};
    wr_req  = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) wq.push_back('{cyc + 1 + i, 0, 16'h0010, 8'h11});
      else            wq.push_back('{cyc + 1 + i, 1, 16'h0020, 8'h22});
    end
    step(4);
    wr_req = '0;
    step(3);
    checks++;
    if (mem[16'h0010] !== 8'h11 || mem[16'h0020] !== 8'h22) begin
      errors++;
      $display("FAIL rr_mem got m10=%h m20=%h want 11 22", mem[16'h0010], mem[16'h0020]);
    end
    checks++;
    if (pending() != 0) begin
      errors++;
      $display("FAIL rr_pending got %0d outstanding want 0", pending());
    end
  endtask

  task automatic test_disp_burst();
`ifdef VRAM_ARB_STALL_CNT_EN
    stall_clr = 1'b1;
    step(1);
    stall_clr = 1'b0;
`endif
    wr_req   = 2'b10;
    disp_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      disp_addr = 16'h1000 + 16'(i);
      aq.push_back('{cyc + 1, disp_addr});
      dq.push_back('{cyc + 3, pat(disp_addr)});
      step(1);
    end
    disp_req = 1'b0;
    wq.push_back('{cyc + 1, 1, 16'h0020, 8'h22});
    step(1);
    wr_req = '0;
    step(4);
    checks++;
    if (pending() != 0) begin
      errors++;
      $display("FAIL burst_pending got %0d outstanding want 0", pending());
    end
`ifdef VRAM_ARB_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd10) begin
      errors++;
      $display("FAIL stall_cnt got %0d want 10", stall_cnt);
    end
`endif
  endtask

  task automatic test_half_duty();
    wr_req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        disp_req  = 1'b1;
        disp_addr = 16'h2000 + 16'(i);
        aq.push_back('{cyc + 1, disp_addr});
        dq.push_back('{cyc + 3, pat(disp_addr)});
      end else begin
        disp_req = 1'b0;
        if (((i - 1) / 2) % 2 == 0) wq.push_back('{cyc + 1, 0, 16'h0010, 8'h11});
        else                        wq.push_back('{cyc + 1, 1, 16'h0020, 8'h22});
      end
      step(1);
    end
    disp_req = 1'b0;
    wr_req   = '0;
    step(5);
    checks++;
    if (pending() != 0) begin
      errors++;
      $display("FAIL half_pending got %0d outstanding want 0", pending());
    end
  endtask

  task automatic test_reset_mid();
    wr_req = 2'b01;
    wq.push_back('{cyc + 1, 0, 16'h0010, 8'h11});
    step(1);
    wr_req    = '0;
    disp_req  = 1'b1;
    disp_addr = 16'h3000;
    step(1);
    disp_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({disp_valid, disp_data, wr_ack, ram_we, ram_addr, ram_wdata} !== '0) begin
      errors++;
      $display("FAIL async_reset got valid=%b data=%h ack=%b we=%b addr=%h wd=%h want all 0",
               disp_valid, disp_data, wr_ack, ram_we, ram_addr, ram_wdata);
    end
    aq.delete();
    dq.delete();
    step(2);
    rst_n  = 1'b1;
    wr_req = 2'b11;
    wq.push_back('{cyc + 1, 0, 16'h0010, 8'h11});
    step(1);
    wr_req = '0;
    step(5);
    checks++;
    if (pending() != 0) begin
      errors++;
      $display("FAIL reset_mid_pending got %0d outstanding want 0", pending());
    end
  endtask

  task automatic test_single_client();
    d1_wr_addr = 16'h0040;
    d1_wr_data = 8'h44;
    d1_wr_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++;
      if (d1_wr_ack !== 1'b1 || d1_ram_we !== 1'b1 || d1_ram_addr !== 16'h0040 ||
          d1_ram_wdata !== 8'h44) begin
        errors++;
        $display("FAIL n1_write[%0d] got ack=%b we=%b addr=%h wd=%h want 1 1 0040 44",
                 i, d1_wr_ack, d1_ram_we, d1_ram_addr, d1_ram_wdata);
      end
    end
    d1_wr_req = 1'b0;
    step(1);
    checks++;
    if (d1_wr_ack !== 1'b0 || d1_ram_we !== 1'b0) begin
      errors++;
      $display("FAIL n1_idle got ack=%b we=%b want 0 0", d1_wr_ack, d1_ram_we);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_disp_burst();
    test_half_duty();
    test_reset_mid();
    test_single_client();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish within 200us want completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
